// File: rtl/axi_dds_nco_bank.sv
// Multi-channel NCO phase generator with an AXI4-Lite control slave. Shadowed FTW/POFF/CH_EN
// registers commit atomically to the active set that drives the per-channel phase accumulators.
module axi_dds_nco_bank #(
  parameter int          NUM_CH             = 4,
  parameter int          PHASE_WIDTH        = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [31:0] ID_VALUE           = 32'hD0500100
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            ce,
  output logic [NUM_CH*PHASE_WIDTH-1:0]   phase_out,
  output logic                            phase_valid,
  output logic [NUM_CH-1:0]               ch_en
);

  localparam int PW = PHASE_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {
    R_CTRL, R_CHEN, R_STATUS, R_ID, R_FTW, R_POFF, R_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_sel(input logic [AW-1:0] addr);
    int unsigned w;
    reg_sel_e    sel;
    w   = 32'(addr[AW-1:2]);
    sel = R_NONE;
    if (w == 0)      sel = R_CTRL;
    else if (w == 1) sel = R_CHEN;
    else if (w == 2) sel = R_STATUS;
    else if (w == 3) sel = R_ID;
    else if (((w - 4) >> 1) < 32'(NUM_CH)) sel = w[0] ? R_POFF : R_FTW;
    return sel;
  endfunction

  function automatic int unsigned decode_ch(input logic [AW-1:0] addr);
    int unsigned w;
    w = 32'(addr[AW-1:2]);
    return (w >= 4) ? ((w - 4) >> 1) : 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  logic                        auto_q, auto_d;
  logic                        pending_q, pending_d;
  logic [NUM_CH-1:0]           chen_sh_q, chen_sh_d, chen_act_q, chen_act_d;
  logic [NUM_CH-1:0][PW-1:0]   ftw_sh_q, ftw_sh_d, ftw_act_q, ftw_act_d;
  logic [NUM_CH-1:0][PW-1:0]   poff_sh_q, poff_sh_d, poff_act_q, poff_act_d;
  logic [NUM_CH-1:0][PW-1:0]   acc_q, phase_q;
  logic                        phase_valid_q;
  logic                        bvalid_q, rvalid_q;
  logic [1:0]                  bresp_q, rresp_q;
  logic [31:0]                 rdata_q;

  logic                        wr_hs, rd_hs;
  reg_sel_e                    wr_sel, rd_sel;
  int unsigned                 wr_ch, rd_ch;
  logic                        wr_err, rd_err;
  logic                        commit, sync_clr, shadow_wr;
  logic [31:0]                 rd_data;

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_hs = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & s00_axi_aresetn;
  assign rd_hs = s00_axi_arvalid & ~rvalid_q & s00_axi_aresetn;

  assign s00_axi_awready = wr_hs;
  assign s00_axi_wready  = wr_hs;
  assign s00_axi_arready = rd_hs;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign phase_out       = phase_q;
  assign phase_valid     = phase_valid_q;
  assign ch_en           = chen_act_q;

  always_comb begin
    wr_sel     = decode_sel(s00_axi_awaddr);
    wr_ch      = decode_ch(s00_axi_awaddr);
    auto_d     = auto_q;
    pending_d  = pending_q;
    chen_sh_d  = chen_sh_q;
    ftw_sh_d   = ftw_sh_q;
    poff_sh_d  = poff_sh_q;
    chen_act_d = chen_act_q;
    ftw_act_d  = ftw_act_q;
    poff_act_d = poff_act_q;
    wr_err     = 1'b1;
    commit     = 1'b0;
    sync_clr   = 1'b0;
    shadow_wr  = 1'b0;
    if (wr_hs) begin
      case (wr_sel)
        R_CTRL: begin
          wr_err = 1'b0;
          if (s00_axi_wstrb[0]) begin
            auto_d   = s00_axi_wdata[0];
            commit   = s00_axi_wdata[1];
            sync_clr = s00_axi_wdata[2];
          end
        end
        R_CHEN: begin
          wr_err    = 1'b0;
          shadow_wr = 1'b1;
          chen_sh_d = NUM_CH'(merge(32'(chen_sh_q), s00_axi_wdata, s00_axi_wstrb));
        end
        R_FTW: begin
          wr_err    = 1'b0;
          shadow_wr = 1'b1;
          for (int unsigned k = 0; k < NUM_CH; k++)
            if (k == wr_ch)
              ftw_sh_d[k] = PW'(merge(32'(ftw_sh_q[k]), s00_axi_wdata, s00_axi_wstrb));
        end
        R_POFF: begin
          wr_err    = 1'b0;
          shadow_wr = 1'b1;
          for (int unsigned k = 0; k < NUM_CH; k++)
            if (k == wr_ch)
              poff_sh_d[k] = PW'(merge(32'(poff_sh_q[k]), s00_axi_wdata, s00_axi_wstrb));
        end
        default: wr_err = 1'b1;
      endcase
    end
    // Auto-commit publishes the whole shadow set, so earlier pending edits go live too.
    if (commit || (shadow_wr && auto_q)) begin
      chen_act_d = chen_sh_d;
      ftw_act_d  = ftw_sh_d;
      poff_act_d = poff_sh_d;
      pending_d  = 1'b0;
    end else if (shadow_wr) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    rd_sel  = decode_sel(s00_axi_araddr);
    rd_ch   = decode_ch(s00_axi_araddr);
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_sel)
      R_CTRL:   rd_data = 32'(auto_q);
      R_CHEN:   rd_data = 32'(chen_sh_q);
      R_STATUS: rd_data = {8'h00, 8'(PW), 8'(NUM_CH), 7'h00, pending_q};
      R_ID:     rd_data = ID_VALUE;
      R_FTW: begin
        for (int unsigned k = 0; k < NUM_CH; k++)
          if (k == rd_ch) rd_data = 32'(ftw_sh_q[k]);
      end
      R_POFF: begin
        for (int unsigned k = 0; k < NUM_CH; k++)
          if (k == rd_ch) rd_data = 32'(poff_sh_q[k]);
      end
      default:  rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      auto_q     <= 1'b0;
      pending_q  <= 1'b0;
      chen_sh_q  <= '0;
      ftw_sh_q   <= '0;
      poff_sh_q  <= '0;
      chen_act_q <= '0;
      ftw_act_q  <= '0;
      poff_act_q <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      auto_q     <= auto_d;
      pending_q  <= pending_d;
      chen_sh_q  <= chen_sh_d;
      ftw_sh_q   <= ftw_sh_d;
      poff_sh_q  <= poff_sh_d;
      chen_act_q <= chen_act_d;
      ftw_act_q  <= ftw_act_d;
      poff_act_q <= poff_act_d;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_err ? 2'b10 : 2'b00;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      acc_q         <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
    end else begin
      phase_valid_q <= ce;
      if (ce) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          phase_q[k] <= acc_q[k] + poff_act_q[k];
          if (chen_act_q[k]) acc_q[k] <= acc_q[k] + ftw_act_q[k];
        end
      end
      // Clearing wins over a same-cycle accumulate; phase_q still shows the pre-clear value.
      if (sync_clr) acc_q <= '0;
    end
  end

endmodule

// File: doc/axi_dds_nco_bank.md
Name: axi_dds_nco_bank

Overview:
Parametrised multi-channel NCO phase generator with an AXI4-Lite control slave; successor to the fixed 4-register DDS slave. It holds NUM_CH phase accumulators, each with a shadowed frequency tuning word (FTW) and phase offset (POFF). Shadows commit to the active set atomically, so all channels retune on the same cycle. Phase words feed the downstream sine LUT/CORDIC stage.

Parameters:
NUM_CH, 4, number of channels, legal 1..30
PHASE_WIDTH, 32, accumulator/output phase width, legal 8..32
C_S_AXI_DATA_WIDTH, 32, AXI data width, fixed at 32
C_S_AXI_ADDR_WIDTH, 8, AXI byte address width
ID_VALUE, 32'hD0500100, constant returned by the ID register

Ports:
s00_axi_aclk  in  1  single clock for the whole block
s00_axi_aresetn  in  1  synchronous active-low reset
s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR/3/1/1  AXI4-Lite write address
s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  AXI4-Lite write data
s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  AXI4-Lite write response
s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR/3/1/1  AXI4-Lite read address
s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  AXI4-Lite read data
ce  in  1  sample clock enable; one phase step per ce cycle
phase_out  out  NUM_CH*PHASE_WIDTH  channel k at bits [k*PW +: PW]
phase_valid  out  1  high one cycle after each ce cycle
ch_en  out  NUM_CH  active channel-enable mask

Behaviour:
- Reset (s00_axi_aresetn=0 at a clock edge): all ready/valid outputs 0, bresp=rresp=0, rdata=0, phase_out=0, phase_valid=0, ch_en=0, all shadow/active/accumulator registers 0, CTRL=0. Reset mid-transaction abandons it; no response is issued.
- Register map (word-aligned, addr[1:0] ignored):
  0x00 CTRL: [0] AUTO_COMMIT (RW); [1] COMMIT (W1, self-clears, reads 0); [2] SYNC_CLR (W1, self-clears, reads 0).
  0x04 CH_EN: [NUM_CH-1:0] RW shadow. Upper bits read 0.
  0x08 STATUS (RO): [0] commit_pending; [15:8] NUM_CH; [23:16] PHASE_WIDTH.
  0x0C ID (RO): ID_VALUE.
  0x10+8k FTW[k], 0x14+8k POFF[k], k<NUM_CH: RW shadow, low PHASE_WIDTH bits stored, upper bits read 0.
- Write channel: accept only when awvalid and wvalid are both high and bvalid=0. awready and wready pulse high together for exactly one cycle. The register updates on the cycle after the handshake (t+1), with bvalid=1 at t+1, held until bready. wstrb is honoured per byte.
- Write response: bresp=OKAY for mapped RW addresses. Unmapped addresses and RO registers return SLVERR (2'b10), and the write is ignored.
- Read channel: arready pulses one cycle when arvalid=1 and rvalid=0. rdata/rvalid are valid at t+1, held until rready. Unmapped addresses return rdata=0 with SLVERR. Reads return shadow values.
- Commit:
  - Any shadow write sets commit_pending.
  - COMMIT written at t: active<=shadow for all FTW/POFF/CH_EN at t+1, and commit_pending clears at t+1.
  - AUTO_COMMIT=1: each shadow write copies to active on the same cycle, t+1; commit_pending stays 0.
  - A shadow write and a COMMIT cannot coincide (one write per transaction).
- Datapath, on a ce=1 cycle:
  - phase_out[k] <= acc[k] + POFF_act[k], mod 2^PW.
  - If ch_en[k]=1, acc[k] <= acc[k] + FTW_act[k], mod 2^PW, wrapping silently.
  - phase_valid <= 1.
  - Disabled channels hold acc, but phase_out still updates.
- Datapath, on a ce=0 cycle: phase_out holds and phase_valid <= 0.
- Latency: 1 cycle from ce to phase_valid. The output reflects the accumulator value before that cycle's increment.
- Active values committed at cycle t are used by a ce at cycle t+1.
- SYNC_CLR written at t: all acc <= 0 at t+1. It overrides an accumulate on that same cycle, and it does not alter phase_out on that cycle.

Test Plan:
- Write 0x00000001..0x00000004 to 0x10,0x14,0x18,0x1C, read back -> equal, bresp/rresp=OKAY, commit_pending=1; read STATUS -> 0x00_20_04_01 with defaults.
- FTW0=0x40000000, CH_EN=1, COMMIT, ce held high -> phase_out[0] sequence 0, 0x40000000, 0x80000000, 0xC0000000, 0 (wrap); phase_valid high each cycle after ce.
- POFF1=0x10, FTW1=0x100, AUTO_COMMIT=1, CH_EN=0x2 -> ch1 outputs 0x10, 0x110, 0x210; channel 0 outputs stay at its POFF.
- Write 0xAABBCCDD to FTW2 with wstrb=4'b0101 over prior 0 -> readback 0x00BB00DD; write to 0x0C and to 0xFC -> SLVERR; read 0xFC -> SLVERR, data 0.
- Running accumulators, write SYNC_CLR while ce=1 -> acc=0 at t+1, next phase_out = POFF; assert s00_axi_aresetn low for one cycle during an outstanding bvalid -> bvalid=0, all phase_out=0, CTRL readback 0.
